// File: rtl/ram_access_ctrl.sv
// CPU-side load/store initiator for a word-wide single-port RAM without byte enables.
// Handles sub-word extraction, sign/zero extension, alignment/range errors and RMW stores.
module ram_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_store,
  output logic              ram_wen,
  input  logic [31:0]       ram_load
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state, state_d;
  logic [1:0]        cnt, cnt_d;
  logic              op_wen, op_wen_d;
  logic              op_uns, op_uns_d;
  logic [1:0]        op_size, op_size_d;
  logic [1:0]        op_lane, op_lane_d;
  logic [31:0]       op_wdata, op_wdata_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [31:0]       ram_store_d, resp_rdata_d;
  logic              ram_wen_d, resp_valid_d, resp_err_d;
  logic              handshake, req_err;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return {{24{b[7] & ~uns}}, b};
      SZ_HALF: return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  // Only the addressed lane is replaced; every other bit of the read word is kept as-is.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign req_ready = (state == IDLE) && !rst;
  assign handshake = req_valid && req_ready;
  assign req_err   = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                   || (req_addr[31:ADDR_W+2] != '0);

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred on any path.
    state_d      = state;
    cnt_d        = cnt;
    op_wen_d     = op_wen;
    op_uns_d     = op_uns;
    op_size_d    = op_size;
    op_lane_d    = op_lane;
    op_wdata_d   = op_wdata;
    ram_addr_d   = ram_addr;
    ram_store_d  = ram_store;
    ram_wen_d    = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state)
      IDLE: begin
        if (handshake) begin
          op_wen_d   = req_wen;
          op_uns_d   = req_unsigned;
          op_size_d  = req_size;
          op_lane_d  = req_addr[1:0];
          op_wdata_d = req_wdata;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            ram_addr_d = req_addr[ADDR_W+1:2];
            if (req_wen && req_size == SZ_WORD) begin
              state_d      = WRITE;
              ram_store_d  = req_wdata;
              ram_wen_d    = 1'b1;
              resp_valid_d = 1'b1;
            end else begin
              // Loads and sub-word stores both start with a read of the whole word.
              state_d = RD_WAIT;
              cnt_d   = 2'(RD_LAT);
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          resp_valid_d = 1'b1;
          if (op_wen) begin
            state_d     = WRITE;
            ram_store_d = merge(ram_load, op_size, op_lane, op_wdata);
            ram_wen_d   = 1'b1;
          end else begin
            state_d      = RESP;
            resp_rdata_d = extract(ram_load, op_size, op_lane, op_uns);
          end
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wen     <= 1'b0;
      op_uns     <= 1'b0;
      op_size    <= '0;
      op_lane    <= '0;
      op_wdata   <= '0;
      ram_addr   <= '0;
      ram_store  <= '0;
      ram_wen    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state      <= state_d;
      cnt        <= cnt_d;
      op_wen     <= op_wen_d;
      op_uns     <= op_uns_d;
      op_size    <= op_size_d;
      op_lane    <= op_lane_d;
      op_wdata   <= op_wdata_d;
      ram_addr   <= ram_addr_d;
      ram_store  <= ram_store_d;
      ram_wen    <= ram_wen_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM, table of requests, scoreboard queues for
// responses and RAM writes, plus reset-abort and held-valid back-to-back sequences.
module tb_ram_access_ctrl;

  parameter int RD_LAT = 1;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err, ram_wen;
  logic [31:0]       resp_rdata, ram_store, ram_load;
  logic [ADDR_W-1:0] ram_addr;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_wen(ram_wen), .ram_load(ram_load)
  );

  // NOTE: the RAM array is not reset; the bench only reads back words it has written.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_store;
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_load = rd_pipe[RD_LAT-1];

  typedef struct {
    string       name;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_wr;
    logic [31:0] exp_wr_data;
  } vec_t;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; int cyc; } wr_t;

  vec_t  tbl[$];
  resp_t resp_q[$];
  wr_t   wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic wen, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic exp_wr, input logic [31:0] exp_wr_data);
    vec_t v;
    v.name = name; v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_wr = exp_wr; v.exp_wr_data = exp_wr_data;
    return v;
  endfunction

  // Scoreboard side: every response and every RAM write must match the head of its queue.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (resp_q.size() == 0) check("resp_valid with nothing pending", {31'd0, resp_valid}, 32'd0);
      else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp cycle", cyc, e.cyc);
      end
    end
    if (ram_wen) begin
      if (wr_q.size() == 0) check("ram_wen with no write pending", {31'd0, ram_wen}, 32'd0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        check("ram_addr on write", {20'd0, ram_addr}, {20'd0, w.addr});
        check("ram_store", ram_store, w.data);
        check("write cycle", cyc, w.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) check("req_ready timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // Entered and left at a negedge; t_hs is the cycle in which the handshake happens.
  task automatic issue(input vec_t v, input bit hold, output int t_hs);
    int lat;
    resp_t r;
    wr_t   w;
    wait_ready();
    req_valid = 1'b1; req_wen = v.wen; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    t_hs = cyc;
    lat = (v.exp_err || (v.wen && v.size == 2'b10)) ? 1 : RD_LAT + 2;
    r.rdata = v.exp_rdata; r.err = v.exp_err; r.cyc = t_hs + lat;
    resp_q.push_back(r);
    if (v.exp_wr) begin
      w.addr = v.addr[ADDR_W+1:2]; w.data = v.exp_wr_data; w.cyc = t_hs + lat;
      wr_q.push_back(w);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    check("pending responses", resp_q.size(), 0);
    check("pending writes", wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, t3, t4, t5;
    vec_t v;

    tbl.push_back(mk("sw 0x10",      1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF));
    tbl.push_back(mk("lw 0x10",      0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 0, 32'h0));
    tbl.push_back(mk("sw 0x10 b",    1, 2'b10, 0, 32'h10,   32'h8070F011, 32'h0,        0, 1, 32'h8070F011));
    tbl.push_back(mk("lb 0x11",      0, 2'b00, 0, 32'h11,   32'h0,        32'hFFFFFFF0, 0, 0, 32'h0));
    tbl.push_back(mk("lbu 0x11",     0, 2'b00, 1, 32'h11,   32'h0,        32'h000000F0, 0, 0, 32'h0));
    tbl.push_back(mk("lh 0x12",      0, 2'b01, 0, 32'h12,   32'h0,        32'hFFFF8070, 0, 0, 32'h0));
    tbl.push_back(mk("lhu 0x12",     0, 2'b01, 1, 32'h12,   32'h0,        32'h00008070, 0, 0, 32'h0));
    tbl.push_back(mk("lb 0x13",      0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 0, 32'h0));
    tbl.push_back(mk("lb 0x10",      0, 2'b00, 0, 32'h10,   32'h0,        32'h00000011, 0, 0, 32'h0));
    tbl.push_back(mk("lh 0x10",      0, 2'b01, 0, 32'h10,   32'h0,        32'hFFFFF011, 0, 0, 32'h0));
    tbl.push_back(mk("sw 0x10 c",    1, 2'b10, 0, 32'h10,   32'h11223344, 32'h0,        0, 1, 32'h11223344));
    tbl.push_back(mk("sb 0x12",      1, 2'b00, 0, 32'h12,   32'hFFFFFFAB, 32'h0,        0, 1, 32'h11AB3344));
    tbl.push_back(mk("sh 0x10",      1, 2'b01, 0, 32'h10,   32'h1234CDEF, 32'h0,        0, 1, 32'h11ABCDEF));
    tbl.push_back(mk("lw 0x10 rmw",  0, 2'b10, 0, 32'h10,   32'h0,        32'h11ABCDEF, 0, 0, 32'h0));
    tbl.push_back(mk("lw 0x11 err",  0, 2'b10, 0, 32'h11,   32'h0,        32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("sh 0x13 err",  1, 2'b01, 0, 32'h13,   32'hFFFF,     32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("size11 err",   0, 2'b11, 0, 32'h10,   32'h0,        32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("lw range err", 0, 2'b10, 0, 32'h4000, 32'h0,        32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("sw range err", 1, 2'b10, 0, 32'h4000, 32'h55555555, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("sw top word",  1, 2'b10, 0, 32'h3FFC, 32'hA5A55A5A, 32'h0,        0, 1, 32'hA5A55A5A));
    tbl.push_back(mk("lbu 0x3FFF",   0, 2'b00, 1, 32'h3FFF, 32'h0,        32'h000000A5, 0, 0, 32'h0));
    tbl.push_back(mk("lb 0x3FFF",    0, 2'b00, 0, 32'h3FFF, 32'h0,        32'hFFFFFFA5, 0, 0, 32'h0));
    tbl.push_back(mk("sb 0x3FFD",    1, 2'b00, 0, 32'h3FFD, 32'h00000000, 32'h0,        0, 1, 32'hA5A5005A));
    tbl.push_back(mk("lh 0x3FFE",    0, 2'b01, 0, 32'h3FFE, 32'h0,        32'hFFFFA5A5, 0, 0, 32'h0));
    tbl.push_back(mk("sw 0x0",       1, 2'b10, 0, 32'h0,    32'h12345678, 32'h0,        0, 1, 32'h12345678));

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset ram_wen", {31'd0, ram_wen}, 32'd0);
    check("reset ram_addr", {20'd0, ram_addr}, 32'd0);
    check("reset ram_store", ram_store, 32'd0);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("req_ready after reset", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    foreach (tbl[i]) issue(tbl[i], 1'b0, t);
    drain();

    // Reset two cycles into an RMW byte store: the write must be abandoned.
    wait_ready();
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("req_ready during rst", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ram_wen after abort", {31'd0, ram_wen}, 32'd0);
    check("resp_valid after abort", {31'd0, resp_valid}, 32'd0);
    check("req_ready after abort", {31'd0, req_ready}, 32'd1);
    repeat (RD_LAT + 3) @(negedge clk);
    check("word 0 untouched", mem[0], 32'h12345678);
    issue(mk("lw 0x0", 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, 32'h0), 1'b0, t);
    drain();

    // req_valid held high across a burst; each request is taken only when ready.
    issue(mk("b2b sw",  1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0, 1, 32'hCAFEF00D), 1'b1, t1);
    issue(mk("b2b err", 1, 2'b01, 0, 32'h21, 32'h1111,     32'h0,        1, 0, 32'h0),        1'b1, t2);
    issue(mk("b2b lw",  0, 2'b10, 0, 32'h20, 32'h0,        32'hCAFEF00D, 0, 0, 32'h0),        1'b1, t3);
    issue(mk("b2b sb",  1, 2'b00, 0, 32'h23, 32'h77,       32'h0,        0, 1, 32'h77FEF00D), 1'b1, t4);
    issue(mk("b2b lbu", 0, 2'b00, 1, 32'h23, 32'h0,        32'h00000077, 0, 0, 32'h0),        1'b0, t5);
    check("gap after word store", t2 - t1, 2);
    check("gap after error", t3 - t2, 2);
    check("gap after load", t4 - t3, RD_LAT + 3);
    check("gap after rmw store", t5 - t4, RD_LAT + 3);
    drain();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- CPU-side initiator for the core-to-RAM interface.
- Accepts one load/store request at a time from the RV32IMA memory stage and drives the word-wide, single-port RAM (word address, store data, write enable, registered-address load data).
- Implements byte/half/word access, load sign/zero extension, misalignment/range checking, and read-modify-write for sub-word stores, since the RAM has no byte enables.

Parameters:
- ADDR_W, 12: RAM word-address width; RAM spans 2^(ADDR_W+2) bytes starting at byte address 0.
- RD_LAT, 1: cycles from the RAM sampling an address to valid ram_load. Legal values 1..3.

Ports:
- clk  input  1  system clock; also feeds the RAM clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads: zero-extend (1) or sign-extend (0).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned/illegal/out-of-range; valid with resp_valid.
- ram_addr  output  ADDR_W  RAM word address.
- ram_store  output  32  RAM write data.
- ram_wen  output  1  RAM write enable.
- ram_load  input  32  RAM read data.

Behaviour:
- Reset values: all outputs registered. Reset drives ram_wen=0, ram_addr=0, ram_store=0, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE. req_ready=0 while rst is high.
- req_ready = (state==IDLE) and not rst. A handshake occurs in cycle T when req_valid and req_ready are both high; all request fields are latched at T.
- Error check at T:
  - size 11 is illegal.
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - req_addr[31:ADDR_W+2]!=0 is out of range.
  - On any error: go to RESP. T+1 gives resp_valid=1, resp_err=1, resp_rdata=0. No RAM write ever occurs.
- States: IDLE, RD_WAIT, WRITE, RESP.
- Word store:
  - T+1: ram_addr=addr[ADDR_W+1:2], ram_store=wdata, ram_wen=1, resp_valid=1 (state WRITE).
  - T+2: ram_wen=0, back in IDLE.
- Load:
  - T+1: ram_addr driven, ram_wen=0, state RD_WAIT.
  - A down-counter waits RD_LAT cycles. ram_load is sampled at the end of cycle T+RD_LAT+1.
  - T+RD_LAT+2: resp_valid=1 with extended data (state RESP).
  - Load latency for RD_LAT=1 is 3 cycles.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Signed loads replicate the MSB of the selected lane into the upper bits; unsigned loads zero-fill.
- Sub-word store (RMW):
  - Read phase is identical to a load.
  - At T+RD_LAT+2 (state WRITE): ram_store = ram_load with the selected lane replaced by wdata[7:0] or wdata[15:0]; ram_wen=1; resp_valid=1.
  - Unselected bytes are preserved bit-exactly.
- ram_wen is high for exactly one cycle per successful store and never during a load or error.
- ram_addr holds its last value between transactions.
- resp_valid is a one-cycle pulse with no backpressure.
- The state after RESP or WRITE is always IDLE. Maximum throughput is one request per 2 cycles (word store or error), otherwise one per RD_LAT+3.
- req_valid while not ready is ignored; the requester holds the request stable.
- Reset mid-operation (any state): next cycle is IDLE with ram_wen=0. A pending RMW write is abandoned with no RAM modification and no resp_valid.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> ram_wen pulse at T+1 with ram_addr=4; load resp_valid at T+3 with rdata=0xDEADBEEF, err=0.
- RAM word 4 = 0x8070F011: lb 0x11 -> 0xFFFFFFF0; lbu 0x11 -> 0x000000F0; lh 0x12 -> 0xFFFF8070; lhu 0x12 -> 0x00008070.
- RAM word 4 = 0x11223344: sb 0xAB to 0x12 -> word becomes 0x11AB3344; sh 0xCDEF to 0x10 -> word becomes 0x11ABCDEF; exactly one ram_wen pulse each.
- lw 0x11, sh 0x13, size=11, and addr 0x00004000 (ADDR_W=12) -> each gives resp_err=1 at T+1, rdata=0, no ram_wen.
- Assert rst at T+2 of sb 0xFF to 0x0 (word 0 = 0x12345678) -> no resp_valid, no ram_wen; word 0 still 0x12345678; req_ready=1 after rst drops.
- RD_LAT=2 build: lw latency 4 cycles, sb resp at T+4; back-to-back requests with req_valid held high are each accepted only when req_ready=1.
